// File: rtl/hls_deadlock_reporter.sv
// Qualifies a persistent HLS deadlock indication and emits one timestamped
// snapshot record per episode over a valid/ready stream.
module hls_deadlock_reporter #(
    parameter int unsigned CONFIRM_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        block,
    input  logic [3:0]  axis_block_sigs,
    input  logic [10:0] inst_idle_sigs,
    input  logic [2:0]  inst_block_sigs,
    input  logic        clear,
    output logic        report_valid,
    input  logic        report_ready,
    output logic [63:0] report_data,
    output logic        deadlock_flag,
    output logic [7:0]  event_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_REPORT  = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    localparam logic [15:0] CONFIRM_W = 16'(CONFIRM_CYCLES);

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    state_t      r_state;
    logic [15:0] r_qcnt;
    logic [31:0] r_ts;
    logic        r_report_valid;
    logic [63:0] r_report_data;
    logic        r_deadlock_flag;
    logic [7:0]  r_event_count;

    logic [15:0] w_qcnt_inc;
    logic        w_capture;
    logic [7:0]  w_count_next;

    assign w_qcnt_inc = r_qcnt + 16'd1;

    // Capture fires on the cycle the qualification count reaches CONFIRM_CYCLES
    always_comb begin
        w_capture = 1'b0;
        case (r_state)
            ST_IDLE:    w_capture = block && (CONFIRM_W == 16'd1);
            ST_CONFIRM: w_capture = block && (w_qcnt_inc == CONFIRM_W);
            default:    w_capture = 1'b0;
        endcase
    end

    // Capture takes precedence over a coincident clear, so the count restarts at 1
    always_comb begin
        w_count_next = r_event_count;
        if (w_capture) begin
            w_count_next = clear ? 8'd1 : sat_inc8(r_event_count);
        end else if (clear) begin
            w_count_next = 8'd0;
        end else begin
            w_count_next = r_event_count;
        end
    end

    // Timestamp, episode FSM, snapshot record and sticky status
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= ST_IDLE;
            r_qcnt          <= 16'd0;
            r_ts            <= 32'd0;
            r_report_valid  <= 1'b0;
            r_report_data   <= 64'd0;
            r_deadlock_flag <= 1'b0;
            r_event_count   <= 8'd0;
        end else begin
            r_ts          <= r_ts + 32'd1;
            r_event_count <= w_count_next;

            if (w_capture) begin
                r_deadlock_flag <= 1'b1;
                r_report_data   <= {r_ts, w_count_next, 6'd0, inst_idle_sigs,
                                    inst_block_sigs, axis_block_sigs};
            end else if (clear) begin
                r_deadlock_flag <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (block) begin
                        r_qcnt <= 16'd1;
                        if (w_capture) begin
                            r_state        <= ST_REPORT;
                            r_report_valid <= 1'b1;
                        end else begin
                            r_state <= ST_CONFIRM;
                        end
                    end
                end
                ST_CONFIRM: begin
                    if (!block) begin
                        r_state <= ST_IDLE;
                        r_qcnt  <= 16'd0;
                    end else begin
                        r_qcnt <= w_qcnt_inc;
                        if (w_capture) begin
                            r_state        <= ST_REPORT;
                            r_report_valid <= 1'b1;
                        end
                    end
                end
                ST_REPORT: begin
                    if (report_ready) begin
                        r_state        <= ST_HOLD;
                        r_report_valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    // One report per episode: re-arm only once block has dropped
                    if (!block) begin
                        r_state <= ST_IDLE;
                        r_qcnt  <= 16'd0;
                    end
                end
                default: begin
                    r_state        <= ST_IDLE;
                    r_qcnt         <= 16'd0;
                    r_report_valid <= 1'b0;
                end
            endcase
        end
    end

    assign report_valid  = r_report_valid;
    assign report_data   = r_report_data;
    assign deadlock_flag = r_deadlock_flag;
    assign event_count   = r_event_count;

endmodule

// File: tb/tb_hls_deadlock_reporter.sv
// Scoreboard bench for hls_deadlock_reporter: expected records are queued at the
// capture cycle and compared when the valid/ready handshake occurs.
module tb_hls_deadlock_reporter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        block = 1'b0;
    logic [3:0]  axis_block_sigs = 4'd0;
    logic [10:0] inst_idle_sigs = 11'd0;
    logic [2:0]  inst_block_sigs = 3'd0;
    logic        clear = 1'b0;
    logic        report_ready = 1'b0;
    logic        report_valid;
    logic [63:0] report_data;
    logic        deadlock_flag;
    logic [7:0]  event_count;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];
    logic [31:0] tb_ts;

    hls_deadlock_reporter #(.CONFIRM_CYCLES(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .block           (block),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .clear           (clear),
        .report_valid    (report_valid),
        .report_ready    (report_ready),
        .report_data     (report_data),
        .deadlock_flag   (deadlock_flag),
        .event_count     (event_count)
    );

    always #5 clock = ~clock;

    // Reference free-running timestamp
    always @(posedge clock) tb_ts <= reset ? 32'd0 : tb_ts + 32'd1;

    // Advance one cycle; on the way, score any handshake seen mid-cycle
    task automatic tick();
        logic [63:0] exp_v;
        @(negedge clock);
        if (!reset && report_valid && report_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL handshake: unexpected record %h, none expected", report_data);
            end else begin
                exp_v = exp_q.pop_front();
                if (report_data !== exp_v) begin
                    miscompares++;
                    $display("FAIL record: got %h expected %h", report_data, exp_v);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic rand_sigs();
        axis_block_sigs = 4'($urandom);
        inst_idle_sigs  = 11'($urandom);
        inst_block_sigs = 3'($urandom);
    endtask

    task automatic push_capture(input logic [7:0] cnt);
        exp_q.push_back({tb_ts, cnt, 6'd0, inst_idle_sigs, inst_block_sigs, axis_block_sigs});
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick(); tick();
        vectors++;
        if (report_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", report_valid); end
        vectors++;
        if (report_data !== 64'd0) begin miscompares++; $display("FAIL reset_data: got %h expected 0", report_data); end
        vectors++;
        if (deadlock_flag !== 1'b0) begin miscompares++; $display("FAIL reset_flag: got %b expected 0", deadlock_flag); end
        vectors++;
        if (event_count !== 8'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", event_count); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_glitch();
        report_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin block = 1'b1; rand_sigs(); tick(); end
        for (int i = 0; i < 20; i++) begin
            block = 1'b0;
            vectors++;
            if (report_valid !== 1'b0) begin miscompares++; $display("FAIL glitch_valid: got %b expected 0", report_valid); end
            tick();
        end
        vectors++;
        if (deadlock_flag !== 1'b0) begin miscompares++; $display("FAIL glitch_flag: got %b expected 0", deadlock_flag); end
        vectors++;
        if (event_count !== 8'd0) begin miscompares++; $display("FAIL glitch_count: got %0d expected 0", event_count); end
    endtask

    task automatic test_latency();
        reset = 1'b1; block = 1'b0; report_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            block = (cyc >= 10 && cyc < 30);
            rand_sigs();
            if (cyc == 25)
                exp_q.push_back({32'd25, 8'd1, 6'd0, inst_idle_sigs, inst_block_sigs, axis_block_sigs});
            vectors++;
            if (report_valid !== 1'(cyc == 26)) begin
                miscompares++;
                $display("FAIL latency_valid cycle %0d: got %b expected %b", cyc, report_valid, cyc == 26);
            end
            tick();
        end
        vectors++;
        if (deadlock_flag !== 1'b1) begin miscompares++; $display("FAIL latency_flag: got %b expected 1", deadlock_flag); end
        vectors++;
        if (event_count !== 8'd1) begin miscompares++; $display("FAIL latency_count: got %0d expected 1", event_count); end
    endtask

    task automatic test_backpressure();
        logic [63:0] held;
        held = 64'd0;
        report_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            block = 1'b1;
            rand_sigs();
            if (i == 15) begin
                held = {tb_ts, 8'd2, 6'd0, inst_idle_sigs, inst_block_sigs, axis_block_sigs};
                exp_q.push_back(held);
            end
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            block = 1'b0;
            rand_sigs();
            vectors++;
            if (report_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid %0d: got %b expected 1", i, report_valid); end
            vectors++;
            if (report_data !== held) begin miscompares++; $display("FAIL bp_data %0d: got %h expected %h", i, report_data, held); end
            tick();
        end
        report_ready = 1'b1;
        tick();
        vectors++;
        if (report_valid !== 1'b0) begin miscompares++; $display("FAIL bp_after: got %b expected 0", report_valid); end
        tick();
        vectors++;
        if (report_valid !== 1'b0) begin miscompares++; $display("FAIL bp_idle: got %b expected 0", report_valid); end
    endtask

    task automatic test_long_episode();
        int nvalid;
        nvalid = 0;
        block = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        vectors++;
        if (event_count !== 8'd0) begin miscompares++; $display("FAIL clear_count: got %0d expected 0", event_count); end
        vectors++;
        if (deadlock_flag !== 1'b0) begin miscompares++; $display("FAIL clear_flag: got %b expected 0", deadlock_flag); end
        report_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            block = 1'b1;
            rand_sigs();
            if (i == 15) push_capture(8'd1);
            if (report_valid) nvalid++;
            tick();
        end
        vectors++;
        if (nvalid != 1) begin miscompares++; $display("FAIL long_reports: got %0d expected 1", nvalid); end
        block = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            block = 1'b1;
            rand_sigs();
            if (i == 15) push_capture(8'd2);
            tick();
        end
        block = 1'b0;
        tick(); tick();
        vectors++;
        if (event_count !== 8'd2) begin miscompares++; $display("FAIL second_count: got %0d expected 2", event_count); end
    endtask

    task automatic test_saturation_clear();
        block = 1'b0; clear = 1'b1; report_ready = 1'b1;
        tick();
        clear = 1'b0;
        for (int n = 1; n <= 256; n++) begin
            for (int i = 0; i < 16; i++) begin
                block = 1'b1;
                rand_sigs();
                if (i == 15) push_capture((n > 255) ? 8'd255 : 8'(n));
                tick();
            end
            block = 1'b0;
            tick(); tick();
        end
        vectors++;
        if (event_count !== 8'd255) begin miscompares++; $display("FAIL sat_count: got %0d expected 255", event_count); end
        vectors++;
        if (deadlock_flag !== 1'b1) begin miscompares++; $display("FAIL sat_flag: got %b expected 1", deadlock_flag); end
        for (int i = 0; i < 16; i++) begin
            block = 1'b1;
            rand_sigs();
            clear = (i == 15);
            if (i == 15) push_capture(8'd1);
            tick();
        end
        clear = 1'b0;
        block = 1'b0;
        tick();
        vectors++;
        if (event_count !== 8'd1) begin miscompares++; $display("FAIL clrcap_count: got %0d expected 1", event_count); end
        vectors++;
        if (deadlock_flag !== 1'b1) begin miscompares++; $display("FAIL clrcap_flag: got %b expected 1", deadlock_flag); end
        tick();
    endtask

    task automatic test_reset_in_report();
        report_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin block = 1'b1; rand_sigs(); tick(); end
        vectors++;
        if (report_valid !== 1'b1) begin miscompares++; $display("FAIL rir_pending: got %b expected 1", report_valid); end
        reset = 1'b1; block = 1'b0;
        tick();
        vectors++;
        if (report_valid !== 1'b0) begin miscompares++; $display("FAIL rir_valid: got %b expected 0", report_valid); end
        vectors++;
        if (report_data !== 64'd0) begin miscompares++; $display("FAIL rir_data: got %h expected 0", report_data); end
        vectors++;
        if (deadlock_flag !== 1'b0) begin miscompares++; $display("FAIL rir_flag: got %b expected 0", deadlock_flag); end
        vectors++;
        if (event_count !== 8'd0) begin miscompares++; $display("FAIL rir_count: got %0d expected 0", event_count); end
        reset = 1'b0; report_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            vectors++;
            if (report_valid !== 1'b0) begin miscompares++; $display("FAIL rir_after %0d: got %b expected 0", i, report_valid); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_latency();
        test_backpressure();
        test_long_episode();
        test_saturation_clear();
        test_reset_in_report();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d records outstanding expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
